// File: rtl/spawn_arbiter.sv
// rtl/spawn_arbiter.sv - two-requester spawn position arbiter with grid alignment, keep-out rejection and fallback
//
// Shares one random-coordinate source between requester 0 (player food)
// and requester 1 (enemy respawn). Each granted request draws candidates
// from rand_cord whitened by a 16-bit XNOR LFSR. Every candidate is snapped
// to the sprite grid and checked against the screen bounds and a keep-out
// box around both snake heads. The first candidate that passes is returned.
// When the retry budget runs out, a fixed fallback position is returned.
//
// Ports:
//   Clk, Reset_n         clock, synchronous active-low reset
//   req[1:0]             one-cycle request pulses, bit i = requester i
//   rand_cord[19:0]      {y[9:0], x[9:0]} random source, sampled in SAMPLE only
//   avoid0_x/_y          player head, sampled in CHECK only
//   avoid1_x/_y          enemy head, sampled in CHECK only
//   ack[1:0]             one-hot, one-cycle completion pulse
//   spawn_x/_y           result, valid from ack and held until the next ack
//   fallback             result is the fallback position, held with spawn_x/_y
//   busy                 FSM not in IDLE
module spawn_arbiter #(
    parameter int GRID       = 16,
    parameter int X_MAX      = 640,
    parameter int Y_MAX      = 480,
    parameter int KEEP_OUT   = 32,
    parameter int MAX_TRIES  = 8,
    parameter int FALLBACK_X = 320,
    parameter int FALLBACK_Y = 240
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [1:0]  req,
    input  logic [19:0] rand_cord,
    input  logic [9:0]  avoid0_x,
    input  logic [9:0]  avoid0_y,
    input  logic [9:0]  avoid1_x,
    input  logic [9:0]  avoid1_y,
    output logic [1:0]  ack,
    output logic [9:0]  spawn_x,
    output logic [9:0]  spawn_y,
    output logic        fallback,
    output logic        busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    localparam logic [9:0]    GRID_MASK = ~10'(GRID - 1);
    localparam logic [9:0]    X_LIMIT   = 10'(X_MAX - GRID);
    localparam logic [9:0]    Y_LIMIT   = 10'(Y_MAX - GRID);
    localparam logic [10:0]   KO_LIMIT  = 11'(KEEP_OUT);
    localparam logic [9:0]    FB_X      = 10'(FALLBACK_X);
    localparam logic [9:0]    FB_Y      = 10'(FALLBACK_Y);
    // tries counts completed rejects; once it reaches this value the
    // current reject is the last one allowed (tries+1 == MAX_TRIES).
    localparam logic [TW-1:0] LAST_TRY  = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_CHECK  = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     pending_q, pending_d;
    logic           grant_q, grant_d;
    logic           last_q, last_d;
    logic [TW-1:0]  tries_q, tries_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [9:0]     cand_x_q, cand_x_d;
    logic [9:0]     cand_y_q, cand_y_d;
    logic [9:0]     spawn_x_d, spawn_y_d;
    logic           fallback_d;
    logic           cand_ok;
    logic           grant_sel;

    // True when (cx,cy) lies strictly inside the box of half-width KEEP_OUT
    // around (ax,ay). Differences are taken as 11-bit signed so that
    // coordinates up to 1023 never wrap.
    function automatic logic in_box(
        input logic [9:0] cx,
        input logic [9:0] cy,
        input logic [9:0] ax,
        input logic [9:0] ay
    );
        logic [10:0] dx;
        logic [10:0] dy;
        logic [10:0] adx;
        logic [10:0] ady;
        dx  = {1'b0, cx} - {1'b0, ax};
        dy  = {1'b0, cy} - {1'b0, ay};
        adx = dx[10] ? (~dx + 11'd1) : dx;
        ady = dy[10] ? (~dy + 11'd1) : dy;
        return (adx < KO_LIMIT) && (ady < KO_LIMIT);
    endfunction

    assign busy = (state_q != S_IDLE);
    assign ack  = (state_q == S_ACK) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

    // A request arriving in its own ack cycle survives the clear and queues.
    assign pending_d = (pending_q & ~ack) | req;

    // Requester 0 wins unless it is idle, or it was the last one granted
    // while requester 1 is also waiting.
    assign grant_sel = ~(pending_q[0] && (last_q || !pending_q[1]));

    assign cand_ok = (cand_x_q <= X_LIMIT) && (cand_y_q <= Y_LIMIT)
                  && !in_box(cand_x_q, cand_y_q, avoid0_x, avoid0_y)
                  && !in_box(cand_x_q, cand_y_q, avoid1_x, avoid1_y);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        tries_d    = tries_q;
        lfsr_d     = lfsr_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        spawn_x_d  = spawn_x;
        spawn_y_d  = spawn_y;
        fallback_d = fallback;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    grant_d = grant_sel;
                    last_d  = grant_sel;
                    tries_d = '0;
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                cand_x_d = (rand_cord[9:0]   ^ lfsr_q[9:0]) & GRID_MASK;
                cand_y_d = (rand_cord[19:10] ^ {lfsr_q[15:10], lfsr_q[3:0]}) & GRID_MASK;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (cand_ok) begin
                    spawn_x_d  = cand_x_q;
                    spawn_y_d  = cand_y_q;
                    fallback_d = 1'b0;
                    state_d    = S_ACK;
                end else begin
                    // XNOR feedback keeps the all-zero reset state on the
                    // sequence, so the first draw after reset is raw rand_cord.
                    lfsr_d  = {lfsr_q[14:0],
                               ~(lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10])};
                    tries_d = tries_q + 1'b1;
                    if (tries_q < LAST_TRY) begin
                        state_d = S_SAMPLE;
                    end else begin
                        spawn_x_d  = FB_X;
                        spawn_y_d  = FB_Y;
                        fallback_d = 1'b1;
                        state_d    = S_ACK;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            pending_q <= 2'b00;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            tries_q   <= '0;
            lfsr_q    <= 16'h0000;
            cand_x_q  <= 10'd0;
            cand_y_q  <= 10'd0;
            spawn_x   <= 10'd0;
            spawn_y   <= 10'd0;
            fallback  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            tries_q   <= tries_d;
            lfsr_q    <= lfsr_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            spawn_x   <= spawn_x_d;
            spawn_y   <= spawn_y_d;
            fallback  <= fallback_d;
        end
    end

endmodule

// File: tb/tb_spawn_arbiter.sv
// tb/tb_spawn_arbiter.sv - directed self-checking bench for spawn_arbiter
module tb_spawn_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [1:0]  req;
    logic [19:0] rand_cord;
    logic [9:0]  avoid0_x, avoid0_y, avoid1_x, avoid1_y;
    logic [1:0]  ack;
    logic [9:0]  spawn_x, spawn_y;
    logic        fallback;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam int N = 40;

    logic [1:0] req_seq [0:N-1];
    logic       rst_seq [0:N-1];
    logic [1:0] exp_ack [0:N-1];
    logic [1:0] ack_h   [0:N-1];
    logic       busy_h  [0:N-1];
    logic [9:0] sx_h    [0:N-1];
    logic [9:0] sy_h    [0:N-1];
    logic       fb_h    [0:N-1];

    spawn_arbiter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .rand_cord (rand_cord),
        .avoid0_x  (avoid0_x),
        .avoid0_y  (avoid0_y),
        .avoid1_x  (avoid1_x),
        .avoid1_y  (avoid1_y),
        .ack       (ack),
        .spawn_x   (spawn_x),
        .spawn_y   (spawn_y),
        .fallback  (fallback),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_seq();
        for (int i = 0; i < N; i++) begin
            req_seq[i] = 2'b00;
            rst_seq[i] = 1'b1;
            exp_ack[i] = 2'b00;
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            req     = req_seq[c];
            Reset_n = rst_seq[c];
            ack_h[c]  = ack;
            busy_h[c] = busy;
            sx_h[c]   = spawn_x;
            sy_h[c]   = spawn_y;
            fb_h[c]   = fallback;
            tick();
        end
        req     = 2'b00;
        Reset_n = 1'b1;
    endtask

    task automatic check_acks(input string tag, input int n);
        for (int c = 0; c < n; c++)
            check($sformatf("%s_ack_c%0d", tag, c), 32'(ack_h[c]), 32'(exp_ack[c]));
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        req     = 2'b00;
        tick();
        tick();
        check("rst_ack", 32'(ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sx", 32'(spawn_x), 0);
        check("rst_sy", 32'(spawn_y), 0);
        check("rst_fb", 32'(fallback), 0);
        Reset_n = 1'b1;
        clear_seq();
    endtask

    initial begin
        Reset_n   = 1'b0;
        req       = 2'b00;
        rand_cord = 20'd0;
        avoid0_x  = 10'd600; avoid0_y = 10'd400;
        avoid1_x  = 10'd600; avoid1_y = 10'd400;
        clear_seq();

        // Single request, first attempt passes
        do_reset();
        rand_cord  = {10'd100, 10'd200};
        req_seq[0] = 2'b01;
        exp_ack[4] = 2'b01;
        run(8);
        check_acks("single", 8);
        for (int c = 0; c < 8; c++)
            check($sformatf("single_busy_c%0d", c), 32'(busy_h[c]), (c >= 2 && c <= 4) ? 1 : 0);
        check("single_sx", 32'(sx_h[4]), 192);
        check("single_sy", 32'(sy_h[4]), 96);
        check("single_fb", 32'(fb_h[4]), 0);
        check("single_sx_hold", 32'(sx_h[7]), 192);

        // Out of bounds on every attempt -> fallback
        do_reset();
        rand_cord  = {10'd100, 10'd1000};
        avoid0_x = 10'd0; avoid0_y = 10'd0;
        avoid1_x = 10'd0; avoid1_y = 10'd0;
        req_seq[0]  = 2'b10;
        exp_ack[18] = 2'b10;
        run(22);
        check_acks("oob", 22);
        check("oob_busy17", 32'(busy_h[17]), 1);
        check("oob_sx", 32'(sx_h[18]), 320);
        check("oob_sy", 32'(sy_h[18]), 240);
        check("oob_fb", 32'(fb_h[18]), 1);
        check("oob_fb_hold", 32'(fb_h[21]), 1);

        // Keep-out retry: attempts 1-6 land in avoid0's box, 7th (lfsr 003F) passes
        do_reset();
        rand_cord = {10'd100, 10'd200};
        avoid0_x = 10'd192; avoid0_y = 10'd96;
        avoid1_x = 10'd600; avoid1_y = 10'd400;
        req_seq[0]  = 2'b01;
        exp_ack[16] = 2'b01;
        run(20);
        check_acks("keep", 20);
        check("keep_sx", 32'(sx_h[16]), 240);
        check("keep_sy", 32'(sy_h[16]), 96);
        check("keep_fb", 32'(fb_h[16]), 0);

        // Arbitration and buffering
        do_reset();
        rand_cord = {10'd100, 10'd200};
        avoid0_x = 10'd600; avoid0_y = 10'd400;
        req_seq[0]  = 2'b11;
        req_seq[1]  = 2'b01;
        req_seq[2]  = 2'b01;
        req_seq[3]  = 2'b01;
        req_seq[4]  = 2'b11;
        req_seq[14] = 2'b11;
        exp_ack[4]  = 2'b01;
        exp_ack[8]  = 2'b10;
        exp_ack[12] = 2'b01;
        exp_ack[18] = 2'b10;
        exp_ack[22] = 2'b01;
        run(26);
        check_acks("arb", 26);

        // Reset mid-operation
        do_reset();
        req_seq[0] = 2'b01;
        exp_ack[4] = 2'b01;
        run(8);
        check_acks("mr_pre", 8);
        check("mr_pre_sx", 32'(sx_h[7]), 192);
        clear_seq();
        req_seq[0]  = 2'b10;
        rst_seq[3]  = 1'b0;
        req_seq[6]  = 2'b01;
        exp_ack[10] = 2'b01;
        run(14);
        check_acks("mr", 14);
        check("mr_busy3", 32'(busy_h[3]), 1);
        check("mr_busy4", 32'(busy_h[4]), 0);
        check("mr_sx4", 32'(sx_h[4]), 0);
        check("mr_sy4", 32'(sy_h[4]), 0);
        check("mr_fb4", 32'(fb_h[4]), 0);
        check("mr_sx10", 32'(sx_h[10]), 192);
        check("mr_sy10", 32'(sy_h[10]), 96);

        // Request in its own ack cycle queues a second service
        do_reset();
        req_seq[0] = 2'b01;
        req_seq[4] = 2'b01;
        exp_ack[4] = 2'b01;
        exp_ack[8] = 2'b01;
        run(12);
        check_acks("reack", 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spawn_arbiter.md
# spawn_arbiter

- Shares the SoC's single random-coordinate export between two spawn requesters: requester 0 is player food, requester 1 is enemy respawn.
- Arbitrates pending requests round-robin and draws one candidate per attempt from rand_cord, whitened by an internal LFSR.
- Aligns each candidate to the sprite grid and rejects it if it is off-screen or inside a keep-out box around either snake head.
- Returns an accepted position, or a fixed fallback position once the retry budget is spent. Sits between the SoC PIO, the snake modules and the color mapper.

## Interface
Parameters:
- GRID, 16: sprite grid pitch; must be a power of 2.
- X_MAX, 640: screen width in pixels.
- Y_MAX, 480: screen height in pixels.
- KEEP_OUT, 32: half-width of the exclusion box around each avoid point.
- MAX_TRIES, 8: number of attempts before falling back.
- FALLBACK_X, 320: x coordinate returned on fallback.
- FALLBACK_Y, 240: y coordinate returned on fallback.

Ports:
- Clk  in  1: system clock (MAX10_CLK1_50).
- Reset_n  in  1: synchronous, active-low reset.
- req  in  2: one-cycle spawn request pulses; bit i is requester i.
- rand_cord  in  20: {y[19:10], x[9:0]} from the SoC export.
- avoid0_x, avoid0_y  in  10 each: player snake head position.
- avoid1_x, avoid1_y  in  10 each: enemy snake head position.
- ack  out  2: one-hot, one-cycle completion pulse.
- spawn_x, spawn_y  out  10 each: result; valid from the ack cycle, held until the next ack.
- fallback  out  1: set if the result is the fallback position; held with spawn_x/spawn_y.
- busy  out  1: high in any state other than IDLE.

## Operation
Request buffering:
- pending[1:0] register. req[i] sets pending[i]; ack[i] clears it.
- req[i] while pending[i] is already set merges into the existing request.
- req[i] in the same cycle as ack[i]: pending[i] stays set, so a new request is queued.

Arbitration:
- Round-robin with a last-grant pointer. Reset value 1, so requester 0 wins the first tie.
- A grant is taken in IDLE only; the pointer updates on grant.

Finite state machine:
- IDLE: if any pending bit is set, grant and go to SAMPLE; tries=0.
- SAMPLE: register cand_x = rand_cord[9:0] ^ lfsr[9:0] and cand_y = rand_cord[19:10] ^ {lfsr[15:10], lfsr[3:0]}, both masked with ~(GRID-1). Go to CHECK.
- CHECK, pass: load spawn_x/spawn_y with the candidate, fallback=0, go to ACK.
- CHECK, reject: advance the LFSR and increment tries.
  - If tries+1 < MAX_TRIES, go to SAMPLE.
  - Otherwise load FALLBACK_X/FALLBACK_Y, fallback=1, go to ACK.
- ACK: assert ack[grant] for one cycle, then go to IDLE.

Candidate check (combinational in CHECK):
- Pass requires cand_x <= X_MAX-GRID and cand_y <= Y_MAX-GRID.
- Pass also requires that, for each avoid point n, the candidate is not inside its box: reject when |cand_x - avoidn_x| < KEEP_OUT and |cand_y - avoidn_y| < KEEP_OUT.
- Differences are computed as 11-bit signed values, with no wrap.

LFSR:
- 16-bit XNOR LFSR, taps 16,14,13,11: next = {lfsr[14:0], ~(lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10])}.
- Reset value 16'h0000, so the first attempt after reset uses raw rand_cord.
- Advances only on CHECK reject. It is not reset between requests.
- Sequence from reset: 0000, 0001, 0003, 0007, 000F, 001F, 003F, 007F.

## Timing
- Reset values: pending, ack, spawn_x, spawn_y, fallback and busy are 0. State is IDLE, lfsr=0, pointer=1, tries=0.
- Latency, with the req pulse in cycle 0:
  - pending visible in cycle 1 (IDLE).
  - SAMPLE in cycle 2, CHECK in cycle 3.
  - ack in cycle 4 on a first-attempt pass.
  - Each reject adds 2 cycles, so attempt n passing gives ack at cycle 2+2n.
  - Full fallback with MAX_TRIES=8 gives ack at cycle 18.
- Back-to-back requests: the next grant occurs in the IDLE cycle after ACK, giving a minimum 4-cycle service period.
- rand_cord is sampled only in SAMPLE; it may change at any other time.
- Avoid inputs are sampled only in CHECK.
- Reset_n low in any state: on the next edge, return to IDLE, clear pending, issue no ack, and restore every output to its reset value.

## Test plan
Reset is applied before each scenario.
- Single request: rand_cord={10'd100, 10'd200}, avoid points at (600,400). Pulse req[0] in cycle 0 -> ack=2'b01 in cycle 4 only; spawn=(192,96); fallback=0; busy high in cycles 2-4.
- Out of bounds: rand x=1000, y=100, avoid points far away. Pulse req[1] -> all 8 attempts reject; ack=2'b10 in cycle 18; spawn=(320,240); fallback=1.
- Keep-out retry: rand_cord=(200,100), avoid0=(192,96), avoid1=(600,400). Pulse req[0] -> attempts 1-6 reject; attempt 7 (lfsr 003F) passes; ack in cycle 16; spawn=(240,96).
- Arbitration and buffering:
  - Pulse req=2'b11 in cycle 0 -> ack[0] in cycle 4, ack[1] in cycle 8.
  - Extra req[0] pulses in cycles 1-3 -> no extra ack.
  - Then pulse req=2'b11 again -> requester 1 is served first.
- Reset mid-operation: drive Reset_n low in cycle 3 of a request -> all outputs 0 on the next cycle; no ack ever issues; a fresh request after release completes in 4 cycles.
- Request during ack: pulse req[0] exactly in its own ack cycle -> a second ack[0] occurs 4 cycles later.
